// File: rtl/lane_demux_pkg.sv
// Shared lane encodings, sizes and helpers for the lane demultiplexer.
package lane_demux_pkg;

    localparam int unsigned NUM_LANES  = 4;
    localparam int unsigned LANE_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned SEL_W      = 2;

    typedef enum logic [SEL_W-1:0] {
        LANE0 = 2'b00,
        LANE1 = 2'b01,
        LANE2 = 2'b10,
        LANE3 = 2'b11
    } lane_sel_e;

    // One-hot lane enable from a lane select.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
        return NUM_LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/lane_demux_lane_fifo2.sv
// Two-entry lane FIFO with a registered head word that reads zero when empty.
module lane_fifo2
    import lane_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] tail_d;
    logic [CNT_W-1:0] count_d;
    logic             full_d;
    logic             empty_d;
    logic             do_push;
    logic             do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail_q <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            head   <= head_d;
            tail_q <= tail_d;
            count  <= count_d;
            full   <= full_d;
            empty  <= empty_d;
        end
    end

    // A full lane never takes a push, even when it pops in the same cycle.
    always_comb begin
        head_d  = head;
        tail_d  = tail_q;
        count_d = count;
        do_push = push && !full;
        do_pop  = pop && !empty;

        if (do_pop) begin
            if (count == CNT_W'(LANE_DEPTH)) begin
                head_d  = tail_q;
                tail_d  = '0;
                count_d = CNT_W'(1);
            end else if (do_push) begin
                head_d  = push_data;
                count_d = CNT_W'(1);
            end else begin
                head_d  = '0;
                count_d = '0;
            end
        end else if (do_push) begin
            if (empty) begin
                head_d  = push_data;
                count_d = CNT_W'(1);
            end else begin
                tail_d  = push_data;
                count_d = CNT_W'(LANE_DEPTH);
            end
        end

        full_d  = (count_d == CNT_W'(LANE_DEPTH));
        empty_d = (count_d == '0);
    end

endmodule

// File: rtl/lane_demux.sv
// 1-to-4 word demultiplexer steering tagged words into independent 2-entry lane FIFOs.
module lane_demux
    import lane_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3
);

    logic [NUM_LANES-1:0] push;
    logic [NUM_LANES-1:0] pop;
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] empty;
    logic [WIDTH-1:0]     head  [NUM_LANES];
    logic [CNT_W-1:0]     count [NUM_LANES];

    // Ready depends only on registered lane state, never on out_ready.
    assign in_ready = !full[in_sel];
    assign push     = (in_valid && in_ready) ? lane_onehot(in_sel) : '0;
    assign pop      = out_ready & ~empty;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_fifo2 #(
            .WIDTH(WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .push_data (in_data),
            .pop       (pop[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .head      (head[i]),
            .count     (count[i])
        );
        assign out_valid[i] = (count[i] != '0);
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

endmodule

// File: tb/tb_lane_demux.sv
// Testbench for lane_demux: directed scenarios plus random traffic against per-lane queue model.
module tb_lane_demux;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0] od [4];

    int checks = 0;
    int errors = 0;

    // Reference model: each lane is an ordered list of at most two words.
    logic [7:0] mem [4][2];
    int         cnt [4];

    lane_demux #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
    );

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
    endtask

    // One clock: drive inputs after a falling edge, check ready, advance model, check outputs.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        bit   acc;
        logic exp_v;
        logic [7:0] exp_d;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        if (v) begin
            checks++;
            if (in_ready !== (cnt[s] < 2)) begin
                errors++;
                $display("FAIL in_ready sel=%0d: got %b want %b", s, in_ready, (cnt[s] < 2));
            end
        end
        acc = v && (cnt[s] < 2);
        for (int i = 0; i < 4; i++) begin
            if (cnt[i] > 0 && r[i]) begin
                mem[i][0] = mem[i][1];
                cnt[i]--;
            end
        end
        if (acc) begin
            mem[s][cnt[s]] = d;
            cnt[s]++;
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_v = (cnt[i] > 0);
            exp_d = exp_v ? mem[i][0] : 8'h00;
            checks++;
            if (out_valid[i] !== exp_v || od[i] !== exp_d) begin
                errors++;
                $display("FAIL lane%0d output: got v=%b d=%h want v=%b d=%h",
                         i, out_valid[i], od[i], exp_v, exp_d);
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) cycle(1'b0, 2'd0, 8'h00, 4'hf);
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        out_ready = 4'h0;
        rst_n     = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000 || out_data0 !== 8'h00 || out_data1 !== 8'h00 ||
            out_data2 !== 8'h00 || out_data3 !== 8'h00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got v=%b d=%h/%h/%h/%h rdy=%b want v=0000 d=00 rdy=1",
                     out_valid, out_data0, out_data1, out_data2, out_data3, in_ready);
        end
    endtask

    task automatic test_single_word();
        cycle(1'b1, 2'd2, 8'hA5, 4'hf);
        checks++;
        if (out_valid !== 4'b0100 || out_data2 !== 8'hA5) begin
            errors++;
            $display("FAIL single_word: got v=%b d2=%h want v=0100 d2=a5", out_valid, out_data2);
        end
        cycle(1'b0, 2'd0, 8'h00, 4'hf);
        checks++;
        if (out_valid !== 4'b0000) begin
            errors++;
            $display("FAIL single_word_pop: got v=%b want 0000", out_valid);
        end
    endtask

    task automatic test_lane_full();
        cycle(1'b1, 2'd1, 8'h11, 4'b1101);
        cycle(1'b1, 2'd1, 8'h22, 4'b1101);
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h33;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_data1 !== 8'h11) begin
            errors++;
            $display("FAIL lane_full: got rdy=%b d1=%h want rdy=0 d1=11", in_ready, out_data1);
        end
        cycle(1'b1, 2'd1, 8'h33, 4'b1101);
        cycle(1'b1, 2'd1, 8'h33, 4'hf);
        checks++;
        if (out_data1 !== 8'h22) begin
            errors++;
            $display("FAIL lane_full_order: got d1=%h want 22", out_data1);
        end
        cycle(1'b1, 2'd1, 8'h33, 4'hf);
        checks++;
        if (out_data1 !== 8'h33 || out_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL lane_full_accept: got d1=%h v=%b want 33 1", out_data1, out_valid[1]);
        end
        drain();
    endtask

    task automatic test_push_pop_count1();
        cycle(1'b1, 2'd3, 8'h7E, 4'b0000);
        cycle(1'b1, 2'd3, 8'h81, 4'b1000);
        checks++;
        if (out_valid !== 4'b1000 || out_data3 !== 8'h81) begin
            errors++;
            $display("FAIL push_pop_count1: got v=%b d3=%h want 1000 81", out_valid, out_data3);
        end
        cycle(1'b0, 2'd0, 8'h00, 4'hf);
        checks++;
        if (out_valid[3] !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_count1_depth: got v3=%b want 0", out_valid[3]);
        end
    endtask

    task automatic test_isolation();
        cycle(1'b1, 2'd0, 8'hA0, 4'b1110);
        cycle(1'b1, 2'd0, 8'hA1, 4'b1110);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 2'(1 + (k - 1) % 3), 8'(k), 4'b1110);
            checks++;
            if (out_valid[0] !== 1'b1 || out_data0 !== 8'hA0) begin
                errors++;
                $display("FAIL isolation k=%0d: got v0=%b d0=%h want 1 a0", k, out_valid[0], out_data0);
            end
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom), 4'($urandom));
        end
        drain();
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 2'd0, 8'h5A, 4'b0000);
        cycle(1'b1, 2'd0, 8'h5B, 4'b0000);
        cycle(1'b1, 2'd2, 8'hC3, 4'b0000);
        cycle(1'b1, 2'd2, 8'hC4, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0000 || out_data0 !== 8'h00 || out_data2 !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: got v=%b d0=%h d2=%h want 0000 00 00", out_valid, out_data0, out_data2);
        end
        #1 rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        for (int k = 0; k < 4; k++) cycle(1'b0, 2'd0, 8'h00, 4'hf);
        cycle(1'b1, 2'd2, 8'h3C, 4'b0000);
        checks++;
        if (out_valid !== 4'b0100 || out_data2 !== 8'h3C) begin
            errors++;
            $display("FAIL reset_mid_after: got v=%b d2=%h want 0100 3c", out_valid, out_data2);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_lane_full();
        test_push_pop_count1();
        test_isolation();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
